mem_port_arbiter: RTL and testbench

Shares the single-port synchronous program/data memory between two requesters: port 0, the CPU load/store/fetch port, and port 1, the UART debug/loader port. It arbitrates round-robin, one access per cycle, and returns read data one cycle after grant. Port 1 may lock the memory for bounded bursts. It sits in `project` between `cpu`, the UART command engine and the memory macro.

---
 rtl/cpu_pkg.sv | 11 +
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-subsystem types: arbiter state encoding and default word width.
package cpu_pkg;

  localparam int WORD_SIZE = 16;

  typedef enum logic {
    ARB_RR     = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the CPU (port 0)
// and the UART loader (port 1), with bounded port-1 lock bursts; reads return one cycle after grant.
module mem_port_arbiter #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_W    = 8,
  parameter int MAX_LOCK  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic                 we0,
  input  logic [ADDR_W-1:0]    addr0,
  input  logic [WORD_SIZE-1:0] wdata0,
  input  logic                 req1,
  input  logic                 we1,
  input  logic [ADDR_W-1:0]    addr1,
  input  logic [WORD_SIZE-1:0] wdata1,
  input  logic                 lock1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 rvalid0,
  output logic                 rvalid1,
  output logic [WORD_SIZE-1:0] rdata0,
  output logic [WORD_SIZE-1:0] rdata1,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 locked
);
  import cpu_pkg::*;

  localparam logic [7:0] MAX_CNT = 8'(MAX_LOCK);

  arb_state_e state_q;
  logic       last_q;
  logic [7:0] lock_cnt_q;
  logic       pend_rd_q;
  logic       pend_port_q;
  logic       locked_q;
  logic       rd_gnt;

  // Grants are forced low while reset is asserted, even though state is already RR.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset) begin
      if (state_q == ARB_LOCKED) begin
        gnt1 = req1;
      end else if (req0 && req1) begin
        gnt0 = last_q;
        gnt1 = ~last_q;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  always_comb begin
    mem_en    = gnt0 | gnt1;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt0) begin
      mem_we    = we0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (gnt1) begin
      mem_we    = we1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  assign rd_gnt = (gnt0 & ~we0) | (gnt1 & ~we1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ARB_RR;
      last_q      <= 1'b1;
      lock_cnt_q  <= '0;
      pend_rd_q   <= 1'b0;
      pend_port_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      pend_rd_q <= rd_gnt;
      if (rd_gnt) begin
        pend_port_q <= gnt1;
      end
      if (gnt0) begin
        last_q <= 1'b0;
      end else if (gnt1) begin
        last_q <= 1'b1;
      end
      case (state_q)
        ARB_RR: begin
          if (gnt1 && lock1) begin
            state_q    <= ARB_LOCKED;
            locked_q   <= 1'b1;
            lock_cnt_q <= 8'd1;
          end
        end
        ARB_LOCKED: begin
          // Leaving the lock hands priority to port 0.
          if (!lock1 || (gnt1 && lock_cnt_q == MAX_CNT)) begin
            state_q    <= ARB_RR;
            locked_q   <= 1'b0;
            lock_cnt_q <= '0;
            last_q     <= 1'b1;
          end else if (gnt1 && lock_cnt_q != MAX_CNT) begin
            lock_cnt_q <= lock_cnt_q + 8'd1;
          end
        end
        default: begin
          state_q  <= ARB_RR;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign rvalid0 = pend_rd_q & ~pend_port_q;
  assign rvalid1 = pend_rd_q & pend_port_q;
  assign rdata0  = rvalid0 ? mem_rdata : '0;
  assign rdata1  = rvalid1 ? mem_rdata : '0;
  assign locked  = locked_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural single-port memory.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1, lock1;
  logic [7:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we, locked;
  logic [15:0] rdata0, rdata1, mem_wdata, mem_rdata;
  logic [7:0]  mem_addr;

  logic [15:0] mem [256];

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;
  logic fin_chk  = 1'b0;
  logic fin_done = 1'b0;

  logic [28:0] cyc_q [$];
  logic [15:0] rd0_q [$];
  logic [15:0] rd1_q [$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.WORD_SIZE(16), .ADDR_W(8), .MAX_LOCK(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .locked(locked)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  // Monitor: one per-cycle expectation plus read returns whenever rvalid is seen.
  always @(negedge clk) begin
    logic [28:0] exp_v;
    logic [28:0] act_v;
    logic [15:0] exp_d;
    if (cyc_q.size() > 0) begin
      exp_v = cyc_q.pop_front();
      act_v = {gnt0, gnt1, locked, mem_en, mem_we, mem_addr, mem_wdata};
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL cyc%0d gnt/lock/mem got=%h exp=%h", cyc_n, act_v, exp_v);
      end
      cyc_n++;
    end
    if (rvalid0) begin
      total++;
      if (rd0_q.size() == 0) begin
        bad++;
        $display("FAIL rvalid0_unexpected got=1 exp=0 rdata0=%h", rdata0);
      end else begin
        exp_d = rd0_q.pop_front();
        if (rdata0 !== exp_d) begin
          bad++;
          $display("FAIL rdata0 got=%h exp=%h", rdata0, exp_d);
        end
      end
    end else begin
      total++;
      if (rdata0 !== 16'h0) begin
        bad++;
        $display("FAIL rdata0_idle got=%h exp=0000", rdata0);
      end
    end
    if (rvalid1) begin
      total++;
      if (rd1_q.size() == 0) begin
        bad++;
        $display("FAIL rvalid1_unexpected got=1 exp=0 rdata1=%h", rdata1);
      end else begin
        exp_d = rd1_q.pop_front();
        if (rdata1 !== exp_d) begin
          bad++;
          $display("FAIL rdata1 got=%h exp=%h", rdata1, exp_d);
        end
      end
    end else begin
      total++;
      if (rdata1 !== 16'h0) begin
        bad++;
        $display("FAIL rdata1_idle got=%h exp=0000", rdata1);
      end
    end
    if (fin_chk && !fin_done) begin
      total++;
      if (rd0_q.size() != 0 || rd1_q.size() != 0 || cyc_q.size() != 0) begin
        bad++;
        $display("FAIL drain got rd0=%0d rd1=%0d cyc=%0d exp all 0",
                 rd0_q.size(), rd1_q.size(), cyc_q.size());
      end
      fin_done = 1'b1;
    end
  end

  // Drive one cycle of stimulus with hand-computed grant/lock expectations.
  task automatic cyc(input logic r0, input logic w0, input logic [7:0] a0, input logic [15:0] d0,
                     input logic r1, input logic w1, input logic [7:0] a1, input logic [15:0] d1,
                     input logic l1, input logic e0, input logic e1, input logic elk,
                     input logic rx, input logic [15:0] rv);
    logic       ewe;
    logic [7:0] eaddr;
    logic [15:0] ewd;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    lock1 = l1;
    ewe = 1'b0; eaddr = 8'h0; ewd = 16'h0;
    if (e0) begin
      ewe = w0; eaddr = a0; ewd = d0;
    end else if (e1) begin
      ewe = w1; eaddr = a1; ewd = d1;
    end
    cyc_q.push_back({e0, e1, elk, e0 | e1, ewe, eaddr, ewd});
    if (rx) begin
      if (e0) rd0_q.push_back(rv);
      else if (e1) rd1_q.push_back(rv);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    mem[5] = 16'h1234;
    mem[6] = 16'hBEEF;
    mem[7] = 16'h0707;
    mem_rdata = 16'h0;
    reset = 1'b0;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0; lock1 = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset/idle: both requesting while reset low
    cyc(1,0,8'h05,16'h0, 1,0,8'h07,16'h0, 0, 0,0,0, 0,16'h0);
    cyc(1,0,8'h05,16'h0, 1,0,8'h07,16'h0, 0, 0,0,0, 0,16'h0);
    reset = 1'b1;
    cyc(1,0,8'h05,16'h0, 1,0,8'h07,16'h0, 0, 1,0,0, 1,16'h1234);
    cyc(0,0,8'h00,16'h0, 1,0,8'h07,16'h0, 0, 0,1,0, 1,16'h0707);

    // Read pipeline
    cyc(1,0,8'h05,16'h0, 0,0,8'h00,16'h0, 0, 1,0,0, 1,16'h1234);
    cyc(1,0,8'h06,16'h0, 0,0,8'h00,16'h0, 0, 1,0,0, 1,16'hBEEF);

    // Port 1 write so that port 0 owns the next tie
    cyc(0,0,8'h00,16'h0, 1,1,8'h10,16'h5555, 0, 0,1,0, 0,16'h0);

    // Round-robin: 0,1,0,1,0,1
    for (int k = 0; k < 6; k++) begin
      cyc(1,0,8'h05,16'h0, 1,0,8'h06,16'h0, 0, (k % 2) == 0, (k % 2) == 1, 0,
          1, ((k % 2) == 0) ? 16'h1234 : 16'hBEEF);
    end

    // Lock bound (MAX_LOCK=4): lock1 ignored without gnt1, then lock
    cyc(1,0,8'h05,16'h0, 1,1,8'h30,16'hC000, 1, 1,0,0, 1,16'h1234);
    cyc(1,0,8'h05,16'h0, 1,1,8'h31,16'hC001, 1, 0,1,0, 0,16'h0);
    for (int k = 2; k <= 5; k++) begin
      cyc(1,0,8'h05,16'h0, 1,1,8'(8'h30 + k),16'(16'hC000 + k), 1, 0,1,1, 0,16'h0);
    end
    cyc(1,0,8'h05,16'h0, 1,1,8'h36,16'hC006, 1, 1,0,0, 1,16'h1234);
    cyc(0,0,8'h00,16'h0, 1,1,8'h36,16'hC006, 1, 0,1,0, 0,16'h0);
    cyc(0,0,8'h00,16'h0, 1,1,8'h37,16'hC007, 1, 0,1,1, 0,16'h0);
    cyc(0,0,8'h00,16'h0, 0,0,8'h00,16'h0,    0, 0,0,1, 0,16'h0);
    cyc(0,0,8'h00,16'h0, 0,0,8'h00,16'h0,    0, 0,0,0, 0,16'h0);

    // Early unlock with write, then read back
    cyc(0,0,8'h00,16'h0, 1,1,8'h20,16'h00AA, 1, 0,1,0, 0,16'h0);
    cyc(0,0,8'h00,16'h0, 0,0,8'h00,16'h0,    0, 0,0,1, 0,16'h0);
    cyc(1,0,8'h20,16'h0, 0,0,8'h00,16'h0,    0, 1,0,0, 1,16'h00AA);
    cyc(1,0,8'h33,16'h0, 0,0,8'h00,16'h0,    0, 1,0,0, 1,16'hC003);

    // Reset mid-read and mid-lock: the port 1 return must be dropped
    cyc(0,0,8'h00,16'h0, 1,0,8'h07,16'h0, 1, 0,1,0, 0,16'h0);
    reset = 1'b0;
    cyc(1,0,8'h05,16'h0, 0,0,8'h00,16'h0, 0, 0,0,0, 0,16'h0);
    cyc(1,0,8'h05,16'h0, 0,0,8'h00,16'h0, 0, 0,0,0, 0,16'h0);
    reset = 1'b1;
    cyc(1,0,8'h05,16'h0, 0,0,8'h00,16'h0, 0, 1,0,0, 1,16'h1234);
    cyc(0,0,8'h00,16'h0, 0,0,8'h00,16'h0, 0, 0,0,0, 0,16'h0);

    fin_chk = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
